// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and constants for the multiply/divide unit.
package mips_pkg;
  localparam int MDU_ITERS = 32;
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;
  typedef enum logic [1:0] {MDU_IDLE, MDU_CALC, MDU_FINISH} mdu_state_e;
endpackage

// File: rtl/mdu_iter_datapath.sv
// mdu_iter_datapath: one shift-add or restoring-subtract step per cycle on a 2*WIDTH working register.
module mdu_iter_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               div,
  input  logic [2*WIDTH-1:0] ld_acc,
  input  logic [WIDTH-1:0]   ld_opnd,
  output logic [2*WIDTH-1:0] acc
);
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_nxt, div_nxt;
  logic [WIDTH-1:0] opnd_q, opnd_d, diff;
  logic [WIDTH:0] sum;
  logic ge;
  // Multiply: {partial product, remaining multiplier bits}; divide: {remainder, dividend/quotient bits}.
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_nxt = {acc_q[0] ? sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]}, acc_q[WIDTH-1:1]};
    ge      = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_q};
    diff    = acc_q[2*WIDTH-2:WIDTH-1] - opnd_q;
    div_nxt = ge ? {diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};
    acc_d   = load ? ld_acc : step ? (div ? div_nxt : mul_nxt) : acc_q;
    opnd_d  = load ? ld_opnd : opnd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end
  assign acc = acc_q;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = MDU_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(ITERS);
  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_abs, b_abs, quo, rem;
  logic done_q, done_d, div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic accept, load, a_neg, b_neg;
  logic [2*WIDTH-1:0] acc, prod;
  assign a_neg  = ~op[0] & operand_a[WIDTH-1];
  assign b_neg  = ~op[0] & operand_b[WIDTH-1];
  assign a_abs  = a_neg ? -operand_a : operand_a;
  assign b_abs  = b_neg ? -operand_b : operand_b;
  assign accept = state_q == MDU_IDLE && start && !cancel;
  assign load   = accept && !op[2];
  mdu_iter_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (state_q == MDU_CALC),
    .div     (div_q),
    .ld_acc  (op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs}),
    .ld_opnd (op[1] ? b_abs : a_abs),
    .acc     (acc)
  );
  // A zero divisor leaves |a| as remainder, so the dividend-sign fix restores the original operand_a.
  assign prod = (sa_q ^ sb_q) ? -acc : acc;
  assign quo  = (sa_q ^ sb_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    if (load) begin
      state_d = MDU_CALC;
      cnt_d   = '0;
      div_d   = op[1];
      sa_d    = a_neg;
      sb_d    = b_neg;
      dz_d    = op[1] && operand_b == '0;
    end
    if (accept && op == MDU_MTHI) hi_d = operand_a;
    if (accept && op == MDU_MTLO) lo_d = operand_a;
    if (state_q == MDU_CALC) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(ITERS - 1)) state_d = MDU_FINISH;
    end
    if (state_q == MDU_FINISH && !cancel) begin
      state_d = MDU_IDLE;
      done_d  = 1'b1;
      hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d    = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
    end
    if (cancel && state_q != MDU_IDLE) state_d = MDU_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
    end
  end
  assign busy = state_q != MDU_IDLE;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table vectors, corner sequences and randomized ops against an arithmetic model.
module tb_mult_div_unit;
  import mips_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cancel = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (o == MDU_MULT) return 64'(sa * sb);
    if (o == MDU_MULTU) return ua * ub;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == MDU_DIV) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  // act: 0 none, 1 start while busy, 2 cancel, 3 reset -- applied before edge act_at
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int act_at, input int act,
                     output logic [31:0] rh, output logic [31:0] rl,
                     output int lat, output int bsy, output bit saw_done);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bsy = busy ? 1 : 0; saw_done = 1'b0;
    for (int n = 2; n <= 60 && !saw_done; n++) begin
      @(negedge clk);
      if (n == act_at) begin
        if (act == 1) begin start = 1'b1; op = MDU_MULT; operand_a = 32'd9; operand_b = 32'd9; end
        if (act == 2) cancel = 1'b1;
        if (act == 3) reset = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0; reset = 1'b0;
      if (busy) bsy++;
      if (done) begin saw_done = 1'b1; lat = n; end
    end
    rh = hi; rl = lo;
  endtask

  vec_t tbl[8];
  logic [31:0] rh, rl, ra, rb;
  logic [63:0] exp;
  logic [2:0] ro;
  int lat, bsy;
  bit sd;

  initial begin
    tbl[0] = '{MDU_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{MDU_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{MDU_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{MDU_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    tbl[4] = '{MDU_DIVU,  32'd100,        32'd0,         32'd100,       32'hFFFF_FFFF};
    tbl[5] = '{MDU_DIV,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[6] = '{MDU_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    tbl[7] = '{MDU_DIVU,  32'hFFFF_FFF9,  32'd2,         32'd1,         32'h7FFF_FFFC};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);

    for (int i = 0; i < 8; i++) begin
      run(tbl[i].op, tbl[i].a, tbl[i].b, 0, 0, rh, rl, lat, bsy, sd);
      chk($sformatf("vec%0d_done", i), 64'(sd), 64'h1);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bsy), 64'd33);
      chk($sformatf("vec%0d_hi", i), 64'(rh), 64'(tbl[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(rl), 64'(tbl[i].lo));
    end

    // MTHI lands at the accepting edge with no busy/done
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; operand_a = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'h0);
    chk("mthi_lo_kept", 64'(lo), 64'(tbl[7].lo));
    @(posedge clk); #1;
    chk("mthi_no_done", 64'(done), 64'h0);

    // cancel with start in IDLE: start ignored
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = MDU_MTLO; operand_a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_lo", 64'(lo), 64'(tbl[7].lo));
    chk("cancel_start_busy", 64'(busy), 64'h0);

    // reserved op ignored
    @(negedge clk);
    start = 1'b1; op = 3'd6; operand_a = 32'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    chk("reserved_busy", 64'(busy), 64'h0);
    chk("reserved_hi", 64'(hi), 64'h1234);

    run(MDU_MULTU, 32'd3, 32'd5, 5, 1, rh, rl, lat, bsy, sd);
    chk("mid_start_latency", 64'(lat), 64'd34);
    chk("mid_start_hi", 64'(rh), 64'h0);
    chk("mid_start_lo", 64'(rl), 64'd15);

    run(MDU_MULTU, 32'd6, 32'd7, 10, 2, rh, rl, lat, bsy, sd);
    chk("cancel_no_done", 64'(sd), 64'h0);
    chk("cancel_busy_cycles", 64'(bsy), 64'd9);
    chk("cancel_hi", 64'(rh), 64'h0);
    chk("cancel_lo", 64'(rl), 64'd15);

    run(MDU_MULTU, 32'd6, 32'd7, 10, 3, rh, rl, lat, bsy, sd);
    chk("reset_mid_no_done", 64'(sd), 64'h0);
    chk("reset_mid_hi", 64'(rh), 64'h0);
    chk("reset_mid_lo", 64'(rl), 64'h0);
    chk("reset_mid_busy", 64'(busy), 64'h0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      exp = model(ro, ra, rb);
      run(ro, ra, rb, 0, 0, rh, rl, lat, bsy, sd);
      chk($sformatf("rand%0d_op%0d_%h_%h_latency", i, ro, ra, rb), 64'(lat), 64'd34);
      chk($sformatf("rand%0d_op%0d_%h_%h_hilo", i, ro, ra, rb), {rh, rl}, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
